store_data_align: RTL and testbench
===================================

Name: store_data_align

Overview:
- Store-side counterpart of the load extension path. Accepts SB/SH/SW requests from the MEM stage: byte address, raw rs2 data and store type.
- Shifts the data into byte-lane position and generates a 4-bit byte write enable for word-addressed Data Memory.
- A misaligned SH/SW that crosses a word boundary is split into two sequential memory beats under a small FSM with a valid/ready handshake on both sides.

Parameters:
- SPLIT_EN, 1, 1 = split boundary-crossing stores into two beats; 0 = drop them and pulse MisalignErr.
- CNT_W, 16, width of the saturating split-store counter.

Ports:
- CPU_CLK  input  1  clock, rising edge
- CPU_RST_N  input  1  reset, asynchronous, active-low
- ReqValid  input  1  store request valid
- ReqReady  output  1  block can accept a request
- ReqAddr  input  32  byte address (ALU result)
- ReqData  input  32  store data, value in low bits
- StoreType  input  2  00 none, 01 SB, 10 SH, 11 SW
- MemValid  output  1  memory beat valid
- MemReady  input  1  memory accepts beat
- MemAddr  output  30  word address
- MemWE  output  4  byte write enables; bit i covers MemWData[8i+7:8i]
- MemWData  output  32  lane-aligned write data
- MisalignErr  output  1  one-cycle pulse; only when SPLIT_EN=0
- SplitCnt  output  CNT_W  number of split stores issued, saturating

Behaviour:
- Reset (CPU_RST_N=0, asynchronous): state IDLE; MemValid=0, MemAddr=0, MemWE=0, MemWData=0, MisalignErr=0, SplitCnt=0. ReqReady=1 once in IDLE.
- States:
  - IDLE: ReqReady=1. Accept when ReqValid&&ReqReady.
  - BEAT0: first memory beat.
  - BEAT1: second memory beat.
- Decode on accept:
  - o = ReqAddr[1:0]; n = 1/2/4 bytes for SB/SH/SW.
  - span[63:0] = {32'b0, ReqData masked to n bytes} << (8*o).
  - mask[7:0] = ((1<<n)-1) << o.
- StoreType=00 accepted: consumed in one cycle, no beat, stays IDLE.
- Beat 0, registered, asserted the cycle after accept: MemAddr=ReqAddr[31:2], MemWE=mask[3:0], MemWData=span[31:0]; IDLE->BEAT0.
- Beat 1 (only if mask[7:4]!=0): MemAddr=ReqAddr[31:2]+1 mod 2^30 (0x3FFFFFFF wraps to 0), MemWE=mask[7:4], MemWData=span[63:32].
- Handshake: while MemValid=1, MemAddr/MemWE/MemWData hold stable until the cycle with MemValid&&MemReady.
- BEAT0 transitions on handshake:
  - mask[7:4]!=0: to BEAT1, beat-1 values loaded the next cycle, MemValid stays 1.
  - else: MemValid=0, to IDLE.
- BEAT1 on handshake: MemValid=0, to IDLE. SplitCnt increments on entry to BEAT1 and saturates at all-ones.
- ReqReady=0 in BEAT0/BEAT1. A new request is accepted only in the cycle after return to IDLE; no back-to-back overlap.
- MemWE is 0 whenever MemValid=0. MemWData lanes outside MemWE are 0.
- SPLIT_EN=0 with a crossing store: no beat; MisalignErr=1 for exactly the cycle after accept; remains IDLE.
- Aligned and non-crossing misaligned stores (SB any o; SH o=0,1,2; SW o=0) take one beat. Latency accept->MemValid = 1 cycle.
- MemReady held low: beat held indefinitely, no timeout.
- Reset mid-beat: beat abandoned immediately, outputs to reset values, no partial second beat.
- ReqData bits above n bytes are ignored.

Test Plan:
- SW ReqAddr=0x00001000, ReqData=0xDEADBEEF, MemReady=1 -> next cycle MemValid=1, MemAddr=0x0000400, MemWE=1111, MemWData=0xDEADBEEF; one beat; ReqReady back to 1 after.
- SB ReqAddr=0x00000103, ReqData=0x123456A5 -> MemAddr=0x40, MemWE=1000, MemWData=0xA5000000; SH ReqAddr=0x102, ReqData=0xFFFF8001 -> MemWE=1100, MemWData=0x80010000.
- SW ReqAddr=0x00000006, ReqData=0x11223344 -> beat0 MemAddr=1, MemWE=1100, MemWData=0x33440000; beat1 MemAddr=2, MemWE=0011, MemWData=0x00001122; SplitCnt=1.
- SH ReqAddr=0xFFFFFFFF, ReqData=0xBEEF -> beat0 MemAddr=0x3FFFFFFF, MemWE=1000, MemWData=0xEF000000; beat1 MemAddr=0, MemWE=0001, MemWData=0x000000BE.
- MemReady=0 for 5 cycles during a split beat0 -> outputs stable, ReqReady=0 throughout; then beat1 follows; assert CPU_RST_N=0 mid-beat1 -> MemValid=0, SplitCnt=0 immediately.
- SPLIT_EN=0, SW ReqAddr=0x1 -> no MemValid, one-cycle MisalignErr; StoreType=00 request -> no beat, no error.

Source files
------------

// File: rtl/store_data_align.sv
// Store data alignment: places SB/SH/SW data into byte lanes with write enables,
// splitting word-crossing stores into two memory beats under valid/ready handshakes.
module store_data_align #(
    parameter bit          SPLIT_EN = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [31:0]      ReqAddr,
    input  logic [31:0]      ReqData,
    input  logic [1:0]       StoreType,
    output logic             MemValid,
    input  logic             MemReady,
    output logic [29:0]      MemAddr,
    output logic [3:0]       MemWE,
    output logic [31:0]      MemWData,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] SplitCnt
);
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 30;
    localparam int unsigned BEW = 4;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    state_t           state_q, state_d;
    logic             mem_valid_q, mem_valid_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [BEW-1:0]   mem_we_q, mem_we_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic [BEW-1:0]   hi_we_q, hi_we_d;
    logic [DW-1:0]    hi_wdata_q, hi_wdata_d;
    logic             misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

    logic [BEW-1:0]   lanes;
    logic [DW-1:0]    data_m;
    logic [2*DW-1:0]  span;
    logic [2*BEW-1:0] mask;
    logic             accept, crossing, issue;

    // Decode the request into a two-word lane span and byte mask
    always_comb begin
        case (StoreType)
            2'b01:   lanes = 4'b0001;
            2'b10:   lanes = 4'b0011;
            2'b11:   lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        data_m   = ReqData & {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        span     = {32'b0, data_m} << {ReqAddr[1:0], 3'b000};
        mask     = {4'b0, lanes} << ReqAddr[1:0];
        accept   = ReqValid && (state_q == S_IDLE);
        crossing = |mask[7:4];
        issue    = accept && (StoreType != 2'b00) && (!crossing || SPLIT_EN);
    end

    assign ReqReady = (state_q == S_IDLE);

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_BEAT0;
            S_BEAT0: if (MemReady) state_d = (hi_we_q != 4'b0) ? S_BEAT1 : S_IDLE;
            S_BEAT1: if (MemReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_valid_d    = mem_valid_q;
        mem_addr_d     = mem_addr_q;
        mem_we_d       = mem_we_q;
        mem_wdata_d    = mem_wdata_q;
        hi_we_d        = hi_we_q;
        hi_wdata_d     = hi_wdata_q;
        misalign_err_d = 1'b0;
        split_cnt_d    = split_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = ReqAddr[31:2];
                    mem_we_d    = mask[3:0];
                    mem_wdata_d = span[31:0];
                    hi_we_d     = mask[7:4];
                    hi_wdata_d  = span[63:32];
                end else if (accept && (StoreType != 2'b00) && crossing) begin
                    misalign_err_d = 1'b1;
                end
            end
            S_BEAT0: begin
                if (MemReady) begin
                    if (hi_we_q != 4'b0) begin
                        mem_addr_d  = mem_addr_q + AW'(1);
                        mem_we_d    = hi_we_q;
                        mem_wdata_d = hi_wdata_q;
                        if (split_cnt_q != {CNT_W{1'b1}}) split_cnt_d = split_cnt_q + CNT_W'(1);
                    end else begin
                        mem_valid_d = 1'b0;
                        mem_we_d    = 4'b0;
                        mem_wdata_d = 32'b0;
                    end
                end
            end
            S_BEAT1: begin
                if (MemReady) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 4'b0;
                    mem_wdata_d = 32'b0;
                end
            end
            default: begin
                mem_valid_d = 1'b0;
                mem_we_d    = 4'b0;
                mem_wdata_d = 32'b0;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_we_q       <= '0;
            mem_wdata_q    <= '0;
            hi_we_q        <= '0;
            hi_wdata_q     <= '0;
            misalign_err_q <= 1'b0;
            split_cnt_q    <= '0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            hi_we_q        <= hi_we_d;
            hi_wdata_q     <= hi_wdata_d;
            misalign_err_q <= misalign_err_d;
            split_cnt_q    <= split_cnt_d;
        end
    end

    assign MemValid    = mem_valid_q;
    assign MemAddr     = mem_addr_q;
    assign MemWE       = mem_we_q;
    assign MemWData    = mem_wdata_q;
    assign MisalignErr = misalign_err_q;
    assign SplitCnt    = split_cnt_q;
endmodule

// File: tb/tb_store_data_align.sv
// Directed bench for store_data_align: a byte-by-byte reference model fills a
// queue of expected memory beats that are popped as the DUT presents them.
module tb_store_data_align;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_n;
    logic [31:0] req_addr, req_data;
    logic [1:0]  store_type;
    logic        mem_ready;

    logic        req_ready, mem_valid, misalign;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [15:0] split_cnt;

    logic        req_ready_n, mem_valid_n, misalign_n;
    logic [29:0] mem_addr_n;
    logic [3:0]  mem_we_n;
    logic [31:0] mem_wdata_n;
    logic [15:0] split_cnt_n;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    split_exp = 0;

    always #5 clk = ~clk;

    store_data_align #(.SPLIT_EN(1'b1), .CNT_W(16)) dut_s (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqAddr(req_addr), .ReqData(req_data), .StoreType(store_type),
        .MemValid(mem_valid), .MemReady(mem_ready),
        .MemAddr(mem_addr), .MemWE(mem_we), .MemWData(mem_wdata),
        .MisalignErr(misalign), .SplitCnt(split_cnt)
    );

    store_data_align #(.SPLIT_EN(1'b0), .CNT_W(16)) dut_n (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .ReqValid(req_valid_n), .ReqReady(req_ready_n),
        .ReqAddr(req_addr), .ReqData(req_data), .StoreType(store_type),
        .MemValid(mem_valid_n), .MemReady(mem_ready),
        .MemAddr(mem_addr_n), .MemWE(mem_we_n), .MemWData(mem_wdata_n),
        .MisalignErr(misalign_n), .SplitCnt(split_cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: walk the stored bytes one address at a time and sort them into words
    task automatic model_push(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
        beat_t b0, b1;
        int    n;
        logic [31:0] a;
        n = (st == 2'b01) ? 1 : (st == 2'b10) ? 2 : (st == 2'b11) ? 4 : 0;
        b0.addr = addr[31:2];
        b1.addr = addr[31:2] + 30'd1;
        b0.we = 4'b0; b0.data = 32'b0;
        b1.we = 4'b0; b1.data = 32'b0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            if (a[31:2] == b0.addr) begin
                b0.we[a[1:0]] = 1'b1;
                b0.data[8*a[1:0] +: 8] = data[8*k +: 8];
            end else begin
                b1.we[a[1:0]] = 1'b1;
                b1.data[8*a[1:0] +: 8] = data[8*k +: 8];
            end
        end
        if (n > 0) exp_q.push_back(b0);
        if (b1.we != 4'b0) exp_q.push_back(b1);
    endtask

    task automatic check_beat(input string tag, input int second);
        beat_t b;
        b = exp_q.pop_front();
        if (second != 0) split_exp++;
        check({tag, ".addr"}, 64'(mem_addr), 64'(b.addr));
        check({tag, ".we"},   64'(mem_we),   64'(b.we));
        check({tag, ".data"}, 64'(mem_wdata), 64'(b.data));
        check({tag, ".split"}, 64'(split_cnt), 64'(split_exp));
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
        int beat;
        int wait_cyc;
        model_push(addr, data, st);
        req_addr = addr; req_data = data; store_type = st; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        beat = 0;
        if (exp_q.size() == 0) check({tag, ".nobeat"}, 64'(mem_valid), 64'(0));
        while (exp_q.size() != 0) begin
            wait_cyc = 0;
            while (!mem_valid && wait_cyc < 20) begin
                tick();
                wait_cyc++;
            end
            check({tag, ".valid"}, 64'(mem_valid), 64'(1));
            check({tag, ".latency"}, 64'(wait_cyc), 64'(0));
            check({tag, ".busy"}, 64'(req_ready), 64'(0));
            check_beat(tag, beat);
            beat++;
            tick();
        end
        check({tag, ".idle"}, 64'(mem_valid), 64'(0));
        check({tag, ".we0"}, 64'(mem_we), 64'(0));
        check({tag, ".rdy"}, 64'(req_ready), 64'(1));
        check({tag, ".noerr"}, 64'(misalign), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid_n = 1'b0;
        req_addr = '0; req_data = '0; store_type = 2'b00;
        mem_ready = 1'b1;
        #12;
        check("rst.valid", 64'(mem_valid), 64'(0));
        check("rst.addr", 64'(mem_addr), 64'(0));
        check("rst.we", 64'(mem_we), 64'(0));
        check("rst.data", 64'(mem_wdata), 64'(0));
        check("rst.cnt", 64'(split_cnt), 64'(0));
        check("rst.err", 64'(misalign_n), 64'(0));
        rst_n = 1'b1;
        tick();
        check("rst.rdy", 64'(req_ready), 64'(1));

        store("sw_al",  32'h0000_1000, 32'hDEAD_BEEF, 2'b11);
        store("sb_o3",  32'h0000_0103, 32'h1234_56A5, 2'b01);
        store("sh_o2",  32'h0000_0102, 32'hFFFF_8001, 2'b10);
        store("sh_o1",  32'h0000_0201, 32'hAAAA_1357, 2'b10);
        store("sw_sp",  32'h0000_0006, 32'h1122_3344, 2'b11);
        store("sh_wr",  32'hFFFF_FFFF, 32'h0000_BEEF, 2'b10);
        store("sw_o3",  32'h0000_0033, 32'hCAFE_F00D, 2'b11);
        store("none",   32'h0000_0040, 32'h1111_1111, 2'b00);

        // Stall the first beat of a split store, then reset during the second
        mem_ready = 1'b0;
        model_push(32'h0000_0006, 32'h5566_7788, 2'b11);
        req_addr = 32'h0000_0006; req_data = 32'h5566_7788; store_type = 2'b11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall.valid", 64'(mem_valid), 64'(1));
            check("stall.rdy", 64'(req_ready), 64'(0));
            check("stall.addr", 64'(mem_addr), 64'(exp_q[0].addr));
            check("stall.we", 64'(mem_we), 64'(exp_q[0].we));
            check("stall.data", 64'(mem_wdata), 64'(exp_q[0].data));
            tick();
        end
        mem_ready = 1'b1;
        check_beat("stall.b0", 0);
        tick();
        mem_ready = 1'b0;
        check("stall.v1", 64'(mem_valid), 64'(1));
        check_beat("stall.b1", 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valid", 64'(mem_valid), 64'(0));
        check("midrst.we", 64'(mem_we), 64'(0));
        check("midrst.cnt", 64'(split_cnt), 64'(0));
        split_exp = 0;
        exp_q.delete();
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst.rdy", 64'(req_ready), 64'(1));
        tick();
        check("midrst.stay", 64'(mem_valid), 64'(0));

        // Crossing store with splitting disabled
        req_addr = 32'h0000_0001; req_data = 32'h0BAD_F00D; store_type = 2'b11; req_valid_n = 1'b1;
        tick();
        req_valid_n = 1'b0;
        check("nosplit.err", 64'(misalign_n), 64'(1));
        check("nosplit.valid", 64'(mem_valid_n), 64'(0));
        check("nosplit.rdy", 64'(req_ready_n), 64'(1));
        tick();
        check("nosplit.pulse", 64'(misalign_n), 64'(0));
        check("nosplit.valid2", 64'(mem_valid_n), 64'(0));

        store_type = 2'b00; req_valid_n = 1'b1;
        tick();
        req_valid_n = 1'b0;
        check("none_n.err", 64'(misalign_n), 64'(0));
        check("none_n.valid", 64'(mem_valid_n), 64'(0));

        store_type = 2'b10; req_addr = 32'h0000_0081; req_data = 32'h0000_ABCD; req_valid_n = 1'b1;
        tick();
        req_valid_n = 1'b0;
        check("sh_n.err", 64'(misalign_n), 64'(0));
        check("sh_n.valid", 64'(mem_valid_n), 64'(1));
        check("sh_n.we", 64'(mem_we_n), 64'(4'b0110));
        check("sh_n.data", 64'(mem_wdata_n), 64'(32'h00AB_CD00));
        tick();
        check("sh_n.done", 64'(mem_valid_n), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
